// File: rtl/manta_bus_pkg.sv
// Shared Manta bus definitions used by bridge_rx, bridge_tx, the cores and
// the read-response FIFO in front of bridge_tx.
package manta_bus_pkg;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 16;

    // One bus transaction as it travels down the core chain.
    typedef struct packed {
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] data;
        logic                  rw;
        logic                  valid;
    } bus_txn_t;

    // Stored entry width: data alone, or data plus the rw bit when writes
    // are passed through as well.
    function automatic int resp_entry_w(input int data_w, input bit keep_rw);
        return keep_rw ? data_w + 1 : data_w;
    endfunction

endpackage

// File: rtl/bus_resp_fifo_mem.sv
// Register-array storage for bus_resp_fifo: one synchronous write port and
// one asynchronous read port. No reset; occupancy is tracked by the top.
module bus_resp_fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the entry at the write pointer on an accepted push.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bus_resp_fifo.sv
// Read-response buffer between the last core on the Manta bus chain and
// bridge_tx. Captures read responses, holds up to DEPTH of them and hands
// them out over valid/ready. A sticky overflow flag records any drop.
// Optional feature: define BUS_RESP_FIFO_PASSTHRU_EN to enqueue writes too,
// carrying the rw bit with each entry and presenting it on rw_o.
//
// Handshake: valid_o is high whenever the head entry exists and does not
// depend on ready_i; a transfer happens on a rising edge where valid_o and
// ready_i are both high; data_o/rw_o hold steady while valid_o && !ready_i.
module bus_resp_fifo
    import manta_bus_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BUS_ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]       data_i,
    input  logic                    rw_i,
    input  logic                    valid_i,
    output logic [DATA_W-1:0]       data_o,
    output logic                    rw_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef BUS_RESP_FIFO_PASSTHRU_EN
    localparam int ENTRY_W = resp_entry_w(DATA_W, 1'b1);
`else
    localparam int ENTRY_W = resp_entry_w(DATA_W, 1'b0);
`endif

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               push_req, push, pop, full, empty;
    logic [ENTRY_W-1:0] wdata, rdata;

    // The address is not stored; it only exists on the port for bus symmetry.
    logic unused_addr;
    assign unused_addr = ^addr_i;

`ifdef BUS_RESP_FIFO_PASSTHRU_EN
    assign push_req = valid_i;
    assign wdata    = {rw_i, data_i};
    assign rw_o     = valid_o & rdata[DATA_W];
`else
    assign push_req = valid_i & ~rw_i;
    assign wdata    = data_i;
    assign rw_o     = 1'b0;
`endif

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign pop   = ~empty & ready_i;
    // A push into a full FIFO still fits when the head leaves on the same edge.
    assign push  = push_req & (~full | pop);

    // Pointer, occupancy and sticky overflow next-state.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push_req & full & ~pop);
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset wins over push and pop and discards contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    bus_resp_fifo_mem #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    assign valid_o    = ~empty;
    assign data_o     = valid_o ? rdata[DATA_W-1:0] : '0;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_bus_resp_fifo.sv
// Bench for bus_resp_fifo (default build, passthrough disabled).
// A queue-level model tracks the expected contents; a negedge process
// compares every output each cycle, and directed tests pin literal results.
module tb_bus_resp_fifo;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0]       addr_i;
    logic [DATA_W-1:0] data_i;
    logic              rw_i, valid_i, ready_i;
    logic [DATA_W-1:0] data_o;
    logic              rw_o, valid_o, overflow_o;
    logic [3:0]        count_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] model_q[$];
    logic              model_ovf;
    logic              started = 1'b0;
    logic [DATA_W-1:0] dut_pops[$];

    bus_resp_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .rw_i       (rw_i),
        .valid_i    (valid_i),
        .data_o     (data_o),
        .rw_o       (rw_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of read responses with a drop-on-full rule.
    always @(posedge clk) begin
        started <= 1'b1;
        if (rst) begin
            model_q.delete();
            model_ovf <= 1'b0;
        end else begin
            bit do_pop;
            bit want_push;
            do_pop    = (model_q.size() > 0) && ready_i;
            want_push = valid_i && !rw_i;
            if (do_pop) void'(model_q.pop_front());
            if (want_push) begin
                if (model_q.size() < DEPTH) model_q.push_back(data_i);
                else model_ovf <= 1'b1;
            end
        end
    end

    // Scoreboard compare every cycle, plus a log of values the DUT handed out.
    always @(negedge clk) begin
        if (started) begin
            chk("count", 32'(count_o), 32'(model_q.size()));
            chk("valid", 32'(valid_o), 32'(model_q.size() != 0));
            chk("overflow", 32'(overflow_o), 32'(model_ovf));
            chk("rw_o", 32'(rw_o), 32'd0);
            if (model_q.size() != 0) chk("data", 32'(data_o), 32'(model_q[0]));
            if (valid_o && ready_i && !rst) dut_pops.push_back(data_o);
        end
    end

    // Driver: apply one cycle of inputs just after a rising edge.
    task automatic drive(input logic v, input logic rw, input logic [DATA_W-1:0] d,
                         input logic rdy);
        valid_i = v;
        rw_i    = rw;
        data_i  = d;
        ready_i = rdy;
        addr_i  = 16'($urandom_range(0, 16'hFFFF));
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        ready_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; addr_i = '0; data_i = '0; rw_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // 1. reset then idle with ready high
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, '0, 1'b1);
        chk("idle_count", 32'(count_o), 32'd0);

        // 2. single read
        drive(1'b1, 1'b0, 16'h00A5, 1'b0);
        chk("single_valid", 32'(valid_o), 32'd1);
        chk("single_data", 32'(data_o), 32'h00A5);
        drive(1'b0, 1'b0, '0, 1'b1);
        chk("single_empty", 32'(valid_o), 32'd0);
        chk("single_count", 32'(count_o), 32'd0);

        // 3. burst of 8, overflow on the 9th, drain in order
        dut_pops.delete();
        for (int i = 1; i <= 8; i++) drive(1'b1, 1'b0, DATA_W'(i), 1'b0);
        chk("burst_count", 32'(count_o), 32'd8);
        chk("burst_ovf0", 32'(overflow_o), 32'd0);
        drive(1'b1, 1'b0, 16'd9, 1'b0);
        chk("burst_ovf1", 32'(overflow_o), 32'd1);
        chk("burst_count9", 32'(count_o), 32'd8);
        for (int i = 0; i < 9; i++) drive(1'b0, 1'b0, '0, 1'b1);
        chk("burst_npops", 32'(dut_pops.size()), 32'd8);
        for (int i = 0; i < 8 && i < dut_pops.size(); i++)
            chk("burst_order", 32'(dut_pops[i]), 32'(i + 1));
        chk("ovf_sticky", 32'(overflow_o), 32'd1);

        // 4. full with simultaneous push and pop
        do_reset();
        dut_pops.delete();
        for (int i = 1; i <= 8; i++) drive(1'b1, 1'b0, DATA_W'(i), 1'b0);
        drive(1'b1, 1'b0, 16'h0BEE, 1'b1);
        chk("pp_count", 32'(count_o), 32'd8);
        chk("pp_ovf", 32'(overflow_o), 32'd0);
        for (int i = 0; i < 9; i++) drive(1'b0, 1'b0, '0, 1'b1);
        chk("pp_npops", 32'(dut_pops.size()), 32'd9);
        if (dut_pops.size() == 9) begin
            chk("pp_first", 32'(dut_pops[0]), 32'd1);
            chk("pp_last", 32'(dut_pops[8]), 32'h0BEE);
        end

        // 5. writes ignored
        dut_pops.delete();
        drive(1'b1, 1'b1, 16'hAAAA, 1'b0);
        drive(1'b1, 1'b0, 16'h1111, 1'b0);
        drive(1'b1, 1'b1, 16'hBBBB, 1'b0);
        drive(1'b1, 1'b1, 16'hCCCC, 1'b0);
        drive(1'b1, 1'b0, 16'h2222, 1'b0);
        drive(1'b1, 1'b1, 16'hDDDD, 1'b0);
        chk("wr_count", 32'(count_o), 32'd2);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, '0, 1'b1);
        chk("wr_npops", 32'(dut_pops.size()), 32'd2);
        if (dut_pops.size() == 2) begin
            chk("wr_pop0", 32'(dut_pops[0]), 32'h1111);
            chk("wr_pop1", 32'(dut_pops[1]), 32'h2222);
        end

        // 6. reset mid-operation
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, DATA_W'(16'h0300 + i), 1'b0);
        rst = 1'b1;
        drive(1'b1, 1'b0, 16'h0F0F, 1'b1);
        rst = 1'b0;
        chk("mrst_count", 32'(count_o), 32'd0);
        chk("mrst_valid", 32'(valid_o), 32'd0);
        chk("mrst_ovf", 32'(overflow_o), 32'd0);
        dut_pops.delete();
        drive(1'b1, 1'b0, 16'h7777, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b1);
        chk("mrst_npops", 32'(dut_pops.size()), 32'd1);
        if (dut_pops.size() >= 1) chk("mrst_first", 32'(dut_pops[0]), 32'h7777);

        // Mixed traffic; the per-cycle compare covers it against the model.
        for (int i = 0; i < 300; i++)
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                  DATA_W'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 2) == 0));
        for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, '0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
